ex_mw_elastic_pipe: RTL and testbench
=====================================

// Module: ex_mw_elastic_pipe
// PURPOSE
//  Parametrised EX->MW pipeline register. Carries result, write-enable and destination
//  through STAGES elastic slots with a valid/ready handshake, synchronous flush and occupancy count.
//  Sits between the execute stage (RISC-V ALU or CNN co-processor) and memory/write-back.
//  Replaces the fixed single-register EX/MW latch wherever back-pressure or extra depth is needed.
// PARAMETERS
//  N       8   result data width (bits)
//  DEST_W  10  destination address width (bits)
//  STAGES  2   number of register slots, >=1
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  flush      in   1              synchronous clear of all slots
//  in_valid   in   1              EX presents an entry
//  in_ready   out  1              pipe accepts an entry this cycle
//  Res        in   N              execute result
//  W_en       in   1              write-enable for entry
//  dest       in   DEST_W         destination address
//  out_valid  out  1              last slot holds an entry
//  out_ready  in   1              MW consumes the entry
//  Res_reg    out  N              result of last slot
//  Wen_reg    out  1              write-enable of last slot, gated by out_valid
//  dest_reg   out  DEST_W         destination of last slot
//  occupancy  out  $clog2(STAGES+1)  count of valid slots
//  lookup_addr in  DEST_W         bypass lookup address
//  fwd_hit    out  1              bypass match found
//  fwd_data   out  N              bypass result
// BEHAVIOUR
//  - Reset (async, reset=1): all valid bits, Res/Wen/dest fields and occupancy go to 0.
//    in_ready=1, out_valid=0, Wen_reg=0, fwd_hit=0, fwd_data=0. Reset mid-transfer discards all entries.
//  - Slot i (0=youngest, STAGES-1=oldest/output) holds {valid,Res,W_en,dest}.
//    adv[last]=valid[last]&out_ready; adv[i]=valid[i]&(!valid[i+1]|adv[i+1]).
//    Combinational ready chain, no bubbles.
//  - in_ready = !flush & (!valid[0] | adv[0]). Transfer into slot 0 when in_valid&in_ready.
//  - Slot i loads from slot i-1 when valid[i-1]&(!valid[i]|adv[i]). Otherwise it holds.
//    A slot that advances and does not load clears valid.
//  - Latency: entry accepted at edge k is on outputs after edge k+STAGES-1 when unstalled.
//    Throughput 1 entry/cycle. Order preserved. Entries with W_en=0 still occupy slots.
//  - Outputs are driven directly from the last slot's registers.
//    Wen_reg = W_en_slot & valid[last], so a bubble never writes.
//  - occupancy = popcount(valid), registered, range 0..STAGES.
//    Full: occupancy==STAGES and out_ready=0 -> in_ready=0.
//    Full with out_ready=1 -> in_ready=1, simultaneous in/out, occupancy unchanged.
//  - flush=1: all valid bits clear at next edge, occupancy->0, in_valid ignored.
//    If out_valid&out_ready occur in the flush cycle, that output transfer still counts as completed.
//  - out_valid may not depend on out_ready. Once out_valid=1, Res_reg/dest_reg stay stable until consumed or flushed.
// CONFIGURATION
//  - EX_MW_BYPASS_EN defined:
//    fwd_hit=1 when any slot has valid&W_en&(dest==lookup_addr).
//    fwd_data = Res of the youngest matching slot (lowest i). Purely combinational from the slot registers.
//  - EX_MW_BYPASS_EN undefined: fwd_hit=0 and fwd_data=0 constant. Comparators are not built. Ports remain.
// TESTING
//  1. reset=1 mid-stream with 2 entries held -> next cycle out_valid=0, occupancy=0, in_ready=1, Wen_reg=0.
//  2. STAGES=2, out_ready=1, push Res=8'h11,8'h22,8'h33 on consecutive cycles -> out in same order,
//     first one edge after acceptance, no gaps.
//  3. out_ready=0, push 3 entries -> third stalls with in_ready=0, occupancy=2.
//     Raise out_ready -> 8'h11 out, 3rd accepted in same cycle.
//  4. Pipe full, flush=1 with in_valid=1 -> occupancy=0 next cycle. Input not captured, out_valid=0.
//  5. Push W_en=0 entry dest=10'h005 -> out_valid=1, Wen_reg=0, dest_reg=10'h005.
//  6. BYPASS_EN: slot0 {dest=3,Res=8'hAA,W_en=1}, slot1 {dest=3,Res=8'hBB,W_en=1}, lookup_addr=3
//     -> fwd_hit=1, fwd_data=8'hAA. lookup_addr=4 -> fwd_hit=0. Undefined macro -> always 0.

Source files
------------

// File: rtl/ex_mw_elastic_pipe.sv
// EX->MW elastic pipeline register: STAGES valid/ready slots with flush, occupancy and optional bypass lookup.
// Define EX_MW_BYPASS_EN to build the forwarding comparators; otherwise fwd_hit/fwd_data are tied to zero.
module ex_mw_elastic_pipe #(
    parameter int N      = 8,
    parameter int DEST_W = 10,
    parameter int STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  Res,
    input  logic                          W_en,
    input  logic [DEST_W-1:0]             dest,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  Res_reg,
    output logic                          Wen_reg,
    output logic [DEST_W-1:0]             dest_reg,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    input  logic [DEST_W-1:0]             lookup_addr,
    output logic                          fwd_hit,
    output logic [N-1:0]                  fwd_data
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [N-1:0]      r_res  [STAGES];
    logic              r_wen  [STAGES];
    logic [DEST_W-1:0] r_dest [STAGES];
    logic [OCC_W-1:0]  r_occ;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_next;
    logic [N-1:0]      w_src_res  [STAGES];
    logic              w_src_wen  [STAGES];
    logic [DEST_W-1:0] w_src_dest [STAGES];

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < STAGES; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    // Ready ripples back from the output slot so a full pipe still moves when MW consumes.
    assign w_adv[LAST] = r_valid[LAST] & out_ready;
    for (genvar g = 0; g < LAST; g++) begin : g_adv
        assign w_adv[g] = r_valid[g] & (~r_valid[g+1] | w_adv[g+1]);
    end

    assign in_ready = ~flush & (~r_valid[0] | w_adv[0]);

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        if (g == 0) begin : g_first
            assign w_load[g]     = in_valid & in_ready;
            assign w_src_res[g]  = Res;
            assign w_src_wen[g]  = W_en;
            assign w_src_dest[g] = dest;
        end else begin : g_next
            assign w_load[g]     = w_adv[g-1];
            assign w_src_res[g]  = r_res[g-1];
            assign w_src_wen[g]  = r_wen[g-1];
            assign w_src_dest[g] = r_dest[g-1];
        end
        assign w_valid_next[g] = ~flush & (w_load[g] | (r_valid[g] & ~w_adv[g]));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_res[i]  <= '0;
                r_wen[i]  <= 1'b0;
                r_dest[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_next;
            r_occ   <= popcount(w_valid_next);
            for (int i = 0; i < STAGES; i++) begin
                if (w_load[i] && !flush) begin
                    r_res[i]  <= w_src_res[i];
                    r_wen[i]  <= w_src_wen[i];
                    r_dest[i] <= w_src_dest[i];
                end
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign Res_reg   = r_res[LAST];
    assign Wen_reg   = r_wen[LAST] & r_valid[LAST];
    assign dest_reg  = r_dest[LAST];
    assign occupancy = r_occ;

`ifdef EX_MW_BYPASS_EN
    logic          w_fwd_hit;
    logic [N-1:0]  w_fwd_data;

    // Scan oldest to youngest so the youngest matching slot wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = LAST; i >= 0; i--) begin
            if (r_valid[i] && r_wen[i] && (r_dest[i] == lookup_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_res[i];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
`else
    logic w_unused_lookup;
    assign w_unused_lookup = ^lookup_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_ex_mw_elastic_pipe.sv
// Directed and randomised bench for ex_mw_elastic_pipe (STAGES=2) with a queue scoreboard on the output port.
module tb_ex_mw_elastic_pipe;

    localparam int N      = 8;
    localparam int DEST_W = 10;
    localparam int STAGES = 2;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      Res;
    logic              W_en;
    logic [DEST_W-1:0] dest;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      Res_reg;
    logic              Wen_reg;
    logic [DEST_W-1:0] dest_reg;
    logic [1:0]        occupancy;
    logic [DEST_W-1:0] lookup_addr;
    logic              fwd_hit;
    logic [N-1:0]      fwd_data;

    typedef struct {
        logic [N-1:0]      res;
        logic              wen;
        logic [DEST_W-1:0] dest;
    } entry_t;

    entry_t expQ[$];
    int     total = 0;
    int     bad   = 0;

    ex_mw_elastic_pipe #(.N(N), .DEST_W(DEST_W), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Res(Res), .W_en(W_en), .dest(dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .Res_reg(Res_reg), .Wen_reg(Wen_reg), .dest_reg(dest_reg),
        .occupancy(occupancy), .lookup_addr(lookup_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] r, input logic we,
                                 input logic [DEST_W-1:0] d);
        in_valid = v;
        Res      = r;
        W_en     = we;
        dest     = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so a handshake seen here completes at the next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            expQ.delete();
        end else begin
            checkOutput("sb_occupancy", 32'(occupancy), 32'(expQ.size()));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    entry_t e;
                    e = expQ.pop_front();
                    checkOutput("sb_res", 32'(Res_reg), 32'(e.res));
                    checkOutput("sb_wen", 32'(Wen_reg), 32'(e.wen));
                    checkOutput("sb_dest", 32'(dest_reg), 32'(e.dest));
                end
            end
            if (flush) expQ.delete();
            if (in_valid && in_ready) begin
                entry_t n;
                n.res  = Res;
                n.wen  = W_en;
                n.dest = dest;
                expQ.push_back(n);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        lookup_addr = '0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_wen_reg", 32'(Wen_reg), 32'd0);
        checkOutput("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        checkOutput("rst_fwd_data", 32'(fwd_data), 32'd0);
        reset = 1'b0;
        tick();

        // Streaming with out_ready high: one-edge latency, no gaps, order kept.
        out_ready = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b1, 10'h001);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b1, 10'h002);
        tick();
        checkOutput("stream_valid0", 32'(out_valid), 32'd1);
        checkOutput("stream_res0", 32'(Res_reg), 32'h11);
        applyStimulus(1'b1, 8'h33, 1'b1, 10'h003);
        tick();
        checkOutput("stream_valid1", 32'(out_valid), 32'd1);
        checkOutput("stream_res1", 32'(Res_reg), 32'h22);
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("stream_valid2", 32'(out_valid), 32'd1);
        checkOutput("stream_res2", 32'(Res_reg), 32'h33);
        tick();
        checkOutput("stream_drained", 32'(out_valid), 32'd0);

        // Back-pressure: third entry stalls until MW consumes, then enters in the same cycle.
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h11, 1'b1, 10'h011);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b1, 10'h012);
        tick();
        applyStimulus(1'b1, 8'h33, 1'b1, 10'h013);
        #1;
        checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
        checkOutput("bp_occupancy", 32'(occupancy), 32'd2);
        tick();
        checkOutput("bp_hold_res", 32'(Res_reg), 32'h11);
        checkOutput("bp_hold_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_pass", 32'(in_ready), 32'd1);
        tick();
        checkOutput("bp_after_res", 32'(Res_reg), 32'h22);
        checkOutput("bp_after_occ", 32'(occupancy), 32'd2);
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("bp_drained_occ", 32'(occupancy), 32'd0);

        // Flush of a full pipe while EX keeps presenting an entry.
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h44, 1'b1, 10'h021);
        tick();
        applyStimulus(1'b1, 8'h66, 1'b1, 10'h022);
        tick();
        applyStimulus(1'b1, 8'hCC, 1'b1, 10'h023);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("flush_no_capture", 32'(out_valid), 32'd0);

        // Flush coinciding with an output handshake: the oldest entry still counts as delivered.
        applyStimulus(1'b1, 8'h77, 1'b1, 10'h031);
        tick();
        applyStimulus(1'b1, 8'h88, 1'b1, 10'h032);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_out_occ", 32'(occupancy), 32'd0);

        // An entry without write-enable still travels but never writes.
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h55, 1'b0, 10'h005);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("nowen_valid", 32'(out_valid), 32'd1);
        checkOutput("nowen_wen_reg", 32'(Wen_reg), 32'd0);
        checkOutput("nowen_dest", 32'(dest_reg), 32'h005);
        out_ready = 1'b1;
        tick();

        // Bypass lookup: both slots match dest 3, youngest (slot 0) must win.
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'hBB, 1'b1, 10'h003);
        tick();
        applyStimulus(1'b1, 8'hAA, 1'b1, 10'h003);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        lookup_addr = 10'h003;
        #1;
`ifdef EX_MW_BYPASS_EN
        checkOutput("fwd_hit_match", 32'(fwd_hit), 32'd1);
        checkOutput("fwd_data_match", 32'(fwd_data), 32'hAA);
`else
        checkOutput("fwd_hit_off", 32'(fwd_hit), 32'd0);
        checkOutput("fwd_data_off", 32'(fwd_data), 32'd0);
`endif
        lookup_addr = 10'h004;
        #1;
        checkOutput("fwd_hit_miss", 32'(fwd_hit), 32'd0);

        // Reset in the middle of a stream with two entries held.
        reset = 1'b1;
        tick();
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_occ", 32'(occupancy), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_wen_reg", 32'(Wen_reg), 32'd0);
        reset = 1'b0;
        tick();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                          10'($urandom));
            out_ready   = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 19) == 0);
            lookup_addr = 10'($urandom_range(0, 3));
            tick();
        end

        applyStimulus(1'b0, '0, 1'b0, '0);
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && occupancy != 0; i++) tick();
        tick();
        checkOutput("drain_occ", 32'(occupancy), 32'd0);
        checkOutput("drain_queue", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
